// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: walks every output element C[i][j] of an N x N product,
// issuing one accumulator clear, N multiply-accumulate steps and one result
// write per element, framed by a start/done handshake with the host.
module matmul_seq_ctrl #(
    parameter  int N  = 2,
    localparam int IW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op_valid,
    output logic          busy,
    output logic          done,
    output logic          acc_clear,
    output logic          acc_ld,
    output logic [IW-1:0] a_row,
    output logic [IW-1:0] k_idx,
    output logic [IW-1:0] b_col,
    output logic          c_we,
    output logic [IW-1:0] c_row,
    output logic [IW-1:0] c_col
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Last legal index value; wrap compares against this exactly so that
    // non-power-of-two N never lets an index run past N-1.
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [2:0]    r_state;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_k;

    logic w_iLast;
    logic w_jLast;
    logic w_kLast;

    assign w_iLast = (r_i == LAST);
    assign w_jLast = (r_j == LAST);
    assign w_kLast = (r_k == LAST);

    // State and index sequencing: row-major walk over (i, j), inner k loop
    // advancing only on cycles where an operand pair is available.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (op_valid) begin
                        if (w_kLast) begin
                            r_k     <= '0;
                            r_state <= S_WB;
                        end else begin
                            r_k <= r_k + IW'(1);
                        end
                    end
                end
                S_WB: begin
                    if (w_iLast && w_jLast) begin
                        // Indices return to zero so DONE and IDLE read 0.
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_CLR;
                        if (w_jLast) begin
                            r_j <= '0;
                            r_i <= r_i + IW'(1);
                        end else begin
                            r_j <= r_j + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Control strobes are decodes of the state register; acc_ld alone also
    // follows op_valid so a stalled MAC cycle holds the accumulator.
    assign busy      = (r_state == S_CLR) || (r_state == S_MAC) || (r_state == S_WB);
    assign done      = (r_state == S_DONE);
    assign acc_clear = (r_state == S_CLR);
    assign acc_ld    = (r_state == S_MAC) && op_valid;
    assign c_we      = (r_state == S_WB);

    assign a_row = r_i;
    assign b_col = r_j;
    assign k_idx = r_k;
    assign c_row = r_i;
    assign c_col = r_j;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: drives an N=2 and an N=3 instance of the sequencer and
// compares every cycle of their outputs against expected traces.
module tb_matmul_seq_ctrl;

    logic clk = 1'b0;

    logic rst2, start2, ov2;
    logic busy2, done2, clr2, ld2, we2;
    logic [0:0] arow2, kidx2, bcol2, crow2, ccol2;

    logic rst3, start3, ov3;
    logic busy3, done3, clr3, ld3, we3;
    logic [1:0] arow3, kidx3, bcol3, crow3, ccol3;

    int testsRun = 0;
    int testsFailed = 0;

    bit ovPlan [0:511];

    typedef struct {
        int start; int ov;
        int busy; int done; int clr; int ld; int we;
        int i; int j; int k;
    } vec_t;

    vec_t tbl [0:18];

    matmul_seq_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .op_valid(ov2),
        .busy(busy2), .done(done2), .acc_clear(clr2), .acc_ld(ld2),
        .a_row(arow2), .k_idx(kidx2), .b_col(bcol2),
        .c_we(we2), .c_row(crow2), .c_col(ccol2)
    );

    matmul_seq_ctrl #(.N(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .op_valid(ov3),
        .busy(busy3), .done(done3), .acc_clear(clr3), .acc_ld(ld3),
        .a_row(arow3), .k_idx(kidx3), .b_col(bcol3),
        .c_we(we3), .c_row(crow3), .c_col(ccol3)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Packed view: {busy,done,clr,ld,we, a_row,k_idx,b_col,c_row,c_col}.
    function automatic logic [24:0] packExp(int busy, int done, int clr, int ld,
                                            int we, int i, int j, int k);
        return {busy[0], done[0], clr[0], ld[0], we[0],
                4'(i), 4'(k), 4'(j), 4'(i), 4'(j)};
    endfunction

    function automatic logic [24:0] sampleDut(int sel);
        if (sel == 2)
            return {busy2, done2, clr2, ld2, we2,
                    4'(arow2), 4'(kidx2), 4'(bcol2), 4'(crow2), 4'(ccol2)};
        return {busy3, done3, clr3, ld3, we3,
                4'(arow3), 4'(kidx3), 4'(bcol3), 4'(crow3), 4'(ccol3)};
    endfunction

    task automatic driveInputs(int sel, bit st, bit ov, bit rs);
        if (sel == 2) begin
            start2 = st; ov2 = ov; rst2 = rs;
        end else begin
            start3 = st; ov3 = ov; rst3 = rs;
        end
    endtask

    task automatic checkOutput(string name, logic [24:0] act, logic [24:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkInt(string name, int act, int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic planOv(int stallPct);
        for (int c = 0; c < 512; c++)
            ovPlan[c] = (c >= 300) ? 1'b1 : ($urandom_range(99) >= stallPct);
    endtask

    // Runs one full product from an IDLE cycle (cycle 0, start high) through
    // DONE. The expected trace comes from nested loops over the elements,
    // consuming the op_valid plan: k advances only when an operand arrives.
    task automatic applyStimulus(int sel, int n, bit holdStart, string tag,
                                 output int firstWe, output int doneAt,
                                 output int maxIdx);
        logic [24:0] expQ[$];
        logic [24:0] act;
        int c;
        int k;
        expQ.push_back(packExp(0, 0, 0, 0, 0, 0, 0, 0));
        c = 1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                expQ.push_back(packExp(1, 0, 1, 0, 0, i, j, 0));
                c++;
                k = 0;
                while (k < n) begin
                    expQ.push_back(packExp(1, 0, 0, int'(ovPlan[c]), 0, i, j, k));
                    if (ovPlan[c]) k++;
                    c++;
                end
                expQ.push_back(packExp(1, 0, 0, 0, 1, i, j, 0));
                c++;
            end
        end
        expQ.push_back(packExp(0, 1, 0, 0, 0, 0, 0, 0));
        firstWe = -1;
        doneAt = -1;
        maxIdx = 0;
        for (int cyc = 0; cyc < expQ.size(); cyc++) begin
            @(negedge clk);
            driveInputs(sel, holdStart || (cyc == 0), ovPlan[cyc], 1'b0);
            #1;
            act = sampleDut(sel);
            checkOutput($sformatf("%s cyc%0d", tag, cyc), act, expQ[cyc]);
            if (act[20] && firstWe < 0) firstWe = cyc;
            if (act[23] && doneAt < 0) doneAt = cyc;
            if (int'(act[19:16]) > maxIdx) maxIdx = int'(act[19:16]);
            if (int'(act[15:12]) > maxIdx) maxIdx = int'(act[15:12]);
            if (int'(act[11:8]) > maxIdx) maxIdx = int'(act[11:8]);
        end
    endtask

    task automatic checkIdle(int sel, int cycles, string tag);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            driveInputs(sel, 1'b0, 1'($urandom_range(1)), 1'b0);
            #1;
            checkOutput($sformatf("%s idle%0d", tag, c), sampleDut(sel), '0);
        end
    endtask

    initial begin
        int fw, da, mx;

        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 1};
        tbl[4]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 1, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[7]  = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 1};
        tbl[8]  = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0};
        tbl[9]  = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
        tbl[13] = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
        tbl[14] = '{0, 1, 1, 0, 0, 1, 0, 1, 1, 0};
        tbl[15] = '{0, 1, 1, 0, 0, 1, 0, 1, 1, 1};
        tbl[16] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[17] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        driveInputs(2, 1'b0, 1'b0, 1'b1);
        driveInputs(3, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset N2", sampleDut(2), '0);
        checkOutput("reset N3", sampleDut(3), '0);
        @(negedge clk);
        driveInputs(2, 1'b0, 1'b0, 1'b0);
        driveInputs(3, 1'b0, 1'b0, 1'b0);

        // Table-driven nominal N=2 product.
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            driveInputs(2, tbl[c].start != 0, tbl[c].ov != 0, 1'b0);
            #1;
            checkOutput($sformatf("table cyc%0d", c), sampleDut(2),
                        packExp(tbl[c].busy, tbl[c].done, tbl[c].clr, tbl[c].ld,
                                tbl[c].we, tbl[c].i, tbl[c].j, tbl[c].k));
        end

        // N=2 with op_valid low in cycles 3..5.
        for (int c = 0; c < 512; c++) ovPlan[c] = 1'b1;
        ovPlan[3] = 1'b0; ovPlan[4] = 1'b0; ovPlan[5] = 1'b0;
        applyStimulus(2, 2, 1'b0, "stall N2", fw, da, mx);
        checkInt("stall N2 firstWe", fw, 7);
        checkInt("stall N2 done", da, 20);
        checkIdle(2, 2, "stall N2");

        // N=3 with operands always ready.
        for (int c = 0; c < 512; c++) ovPlan[c] = 1'b1;
        applyStimulus(3, 3, 1'b0, "full N3", fw, da, mx);
        checkInt("full N3 done", da, 46);
        checkInt("full N3 maxIdx", mx, 2);
        checkIdle(3, 2, "full N3");

        // Randomised operand availability on both sizes.
        for (int r = 0; r < 4; r++) begin
            planOv(35);
            applyStimulus(2, 2, 1'b0, $sformatf("rand%0d N2", r), fw, da, mx);
            checkIdle(2, 1, $sformatf("rand%0d N2", r));
            planOv(35);
            applyStimulus(3, 3, 1'b0, $sformatf("rand%0d N3", r), fw, da, mx);
            checkInt($sformatf("rand%0d N3 maxIdx", r), mx, 2);
            checkIdle(3, 1, $sformatf("rand%0d N3", r));
        end

        // start held high for a whole product, then a back-to-back product
        // beginning in the IDLE cycle right after DONE.
        planOv(20);
        applyStimulus(3, 3, 1'b1, "hold N3", fw, da, mx);
        planOv(20);
        applyStimulus(3, 3, 1'b0, "b2b N3", fw, da, mx);
        checkIdle(3, 2, "b2b N3");

        // Reset during the second element's MAC, then a fresh product.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            driveInputs(2, tbl[c].start != 0, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("prereset cyc%0d", c), sampleDut(2),
                        packExp(tbl[c].busy, tbl[c].done, tbl[c].clr, tbl[c].ld,
                                tbl[c].we, tbl[c].i, tbl[c].j, tbl[c].k));
        end
        driveInputs(2, 1'b0, 1'b1, 1'b1);
        for (int c = 7; c < 12; c++) begin
            @(negedge clk);
            driveInputs(2, 1'b0, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("postreset cyc%0d", c), sampleDut(2), '0);
        end
        for (int c = 0; c < 512; c++) ovPlan[c] = 1'b1;
        applyStimulus(2, 2, 1'b0, "fresh N2", fw, da, mx);
        checkInt("fresh N2 done", da, 17);
        checkIdle(2, 2, "fresh N2");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencer for the matrix-multiply datapath: walks every output element C[i][j] of an N x N product and drives the clear/load controls of the 4-bit accumulator input mux together with operand and result indices. Each output element gets one accumulator clear, N multiply-accumulate steps and one result write. The block sits between the host start/done handshake and the operand memories, MAC unit and accumulator register.

## Interface
Parameters:
- N, default 2, matrix dimension; legal range 2..8.
- IW, localparam, max(1, clog2(N)), width of every index output.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a full product; sampled only in IDLE.
- op_valid  in  1  operand pair for the current index is available; gates MAC steps.
- busy  out  1  high in CLR, MAC and WB.
- done  out  1  one-cycle pulse after the last result write.
- acc_clear  out  1  drives the accumulator mux clear input.
- acc_ld  out  1  drives the accumulator mux ld input; high means load the MAC sum, low means hold.
- a_row  out  IW  row index i into A.
- k_idx  out  IW  inner index k: column of A and row of B.
- b_col  out  IW  column index j into B.
- c_we  out  1  result write strobe.
- c_row, c_col  out  IW each  destination of the result write; equal to i and j.

## Operation
- States: IDLE, CLR, MAC, WB, DONE.
- IDLE: if start=1, set i=j=k=0 and go to CLR; otherwise stay.
- CLR, one cycle: acc_clear=1, acc_ld=0, then go to MAC.
- MAC:
  - op_valid=1: acc_ld=1. If k=N-1, set k=0 and go to WB; otherwise increment k.
  - op_valid=0: acc_ld=0 and all indices hold. This is a stall with no timeout.
- WB, one cycle: c_we=1, c_row=i, c_col=j.
  - If i=N-1 and j=N-1, go to DONE.
  - Otherwise advance the indices and go to CLR. If j=N-1, set j=0 and increment i; else increment j.
- DONE, one cycle: done=1, then go to IDLE.
- acc_clear and acc_ld are never high in the same cycle. acc_clear=1 therefore always zeroes the accumulator, whatever ld is.
- Outside MAC, acc_ld=0. Outside WB, c_we=0.
- Index outputs are direct register values:
  - a_row=i, b_col=j, k_idx=k.
  - In IDLE and DONE all indices read 0.
- start while busy, or in DONE, is ignored and does not queue.
- op_valid outside MAC is ignored.
- Indices never exceed N-1. Wrap is exact at N-1 for any legal N, including non-powers of two.

## Timing
- Reset: state=IDLE and i=j=k=0. All outputs are 0: busy, done, acc_clear, acc_ld, c_we and every index.
- rst=1 at any point, including mid-MAC, takes effect on the next edge. No done pulse and no c_we follow. The next start restarts from C[0][0].
- Outputs are registered state decodes, with one exception: acc_ld is combinational on op_valid within MAC.
- Cycle numbering with op_valid held high; cycle 0 is the cycle in which start=1 in IDLE:
  - Cycle 1: CLR.
  - Cycles 2..N+1: MAC.
  - Cycle N+2: WB.
  - Each element takes N+2 cycles.
  - The last WB is at cycle N·N·(N+2), and done is in the following cycle.
- Each cycle of op_valid=0 in MAC delays every later event by exactly one cycle.
- Back-to-back products: start may be high in the cycle after DONE, the first cycle back in IDLE. No extra turnaround.

## Test plan
- Reset, then N=2, start pulse, op_valid=1:
  - CLR at cycles 1, 5, 9, 13.
  - acc_ld at cycles 2-3, 6-7, 10-11, 14-15.
  - c_we at cycles 4, 8, 12, 16 with (c_row,c_col) = (0,0), (0,1), (1,0), (1,1).
  - done at cycle 17; busy high for cycles 1-16.
- N=2, op_valid low in cycles 3-5:
  - Indices frozen at i=0, j=0, k=1 and acc_ld=0 throughout.
  - First c_we moves to cycle 7; done moves to cycle 20.
- N=3 (non-power-of-two):
  - 9 writes in row-major order; k_idx sequence 0,1,2 per element.
  - No index ever reads 3; done at cycle 46.
- start held high through the whole run:
  - Exactly one product.
  - A second product begins from the IDLE cycle after done.
- rst asserted during the second element's MAC:
  - All outputs 0 at the next edge; no further c_we; no done.
  - A fresh start yields the full reset-free sequence.
- Across every scenario: acc_clear and acc_ld are never both 1, and c_we is never 1 outside WB.
